// File: rtl/two_gates_pkg.sv
// Shared types and helpers for the two_gates masked-cell characterisation block.
package two_gates_pkg;

    localparam int VEC_W = 4;

    // Input vector ordering: {a, b, r1, r2}, a is the MSB.
    typedef logic [VEC_W-1:0] vec_t;

    // Number of set bits in a 4-bit vector (0..4).
    function automatic logic [2:0] popcount4(input vec_t v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < VEC_W; i++) begin
            cnt = cnt + {2'b00, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/two_gates_core.sv
// Purely combinational masked cell: an AND2 level followed by an XOR3 level.
// Kept as its own module so the two gate levels stay visible and untouched.
module two_gates_core (
    input  logic i_a,
    input  logic i_b,
    input  logic i_r1,
    input  logic i_r2,
    output logic o_y
);

    logic w_and;

    // Gate 1: unmasked product of the data inputs.
    assign w_and = i_a & i_b;

    // Gate 2: product masked by both random bits.
    assign o_y = w_and ^ i_r1 ^ i_r2;

endmodule

// File: rtl/two_gates.sv
// two_gates top: power-good qualification, output/Hamming/count registers.
// Build option: define INPUT_DELAY_EN to add a register stage on
// {in_valid,a,b,r1,r2} ahead of the gate logic (latency 2 instead of 1).
module two_gates
    import two_gates_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             VPWR,
    input  logic             VGND,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic             r1,
    input  logic             r2,
    output logic             out_valid,
    output logic             y,
    output logic [2:0]       hd,
    output logic [CNT_W-1:0] vec_cnt
);

    logic             w_pg;
    logic             w_acc;
    vec_t             w_v;
    logic             w_y_next;

    logic             r_y;
    logic             r_out_valid;
    logic [2:0]       r_hd;
    logic [CNT_W-1:0] r_cnt;
    vec_t             r_prev_v;

    // Rails are good only with VPWR high and VGND low.
    assign w_pg = VPWR & ~VGND;

`ifdef INPUT_DELAY_EN
    logic r_dly_valid;
    vec_t r_dly_v;

    // Input stage: qualify with power-good here, capture data only when accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dly_valid <= 1'b0;
            r_dly_v     <= '0;
        end else begin
            r_dly_valid <= in_valid & w_pg;
            if (in_valid & w_pg) begin
                r_dly_v <= {a, b, r1, r2};
            end
        end
    end

    assign w_acc = r_dly_valid;
    assign w_v   = r_dly_v;
`else
    assign w_acc = in_valid & w_pg;
    assign w_v   = {a, b, r1, r2};
`endif

    two_gates_core u_core (
        .i_a  (w_v[3]),
        .i_b  (w_v[2]),
        .i_r1 (w_v[1]),
        .i_r2 (w_v[0]),
        .o_y  (w_y_next)
    );

    // Result registers: update on acceptance, otherwise hold and drop out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y         <= 1'b0;
            r_out_valid <= 1'b0;
            r_hd        <= 3'd0;
            r_cnt       <= '0;
            r_prev_v    <= '0;
        end else if (w_acc) begin
            r_y         <= w_y_next;
            r_out_valid <= 1'b1;
            r_hd        <= popcount4(w_v ^ r_prev_v);
            r_cnt       <= r_cnt + 1'b1;
            r_prev_v    <= w_v;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    // Bad rails force y low at the pin without disturbing the held state.
    assign y         = r_y & w_pg;
    assign out_valid = r_out_valid;
    assign hd        = r_hd;
    assign vec_cnt   = r_cnt;

endmodule

// File: tb/tb_two_gates.sv
// Self-checking bench for two_gates: scoreboard of expected results compared
// against every out_valid beat captured by a monitor.
module tb_two_gates;

    logic       clk = 1'b0;
    logic       rst;
    logic       VPWR;
    logic       VGND;
    logic       in_valid;
    logic       a, b, r1, r2;
    logic       out_valid;
    logic       y;
    logic [2:0] hd;
    logic [7:0] vec_cnt;

    typedef struct {
        logic       y;
        logic [2:0] hd;
        logic [7:0] cnt;
        int         cyc;
    } res_t;

    res_t exp_q[$];
    res_t obs_q[$];

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit [3:0] m_prev;
    bit [7:0] m_cnt;

    two_gates #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .VPWR      (VPWR),
        .VGND      (VGND),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .r1        (r1),
        .r2        (r2),
        .out_valid (out_valid),
        .y         (y),
        .hd        (hd),
        .vec_cnt   (vec_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: capture every output beat away from the active edge.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            res_t o;
            o.y   = y;
            o.hd  = hd;
            o.cnt = vec_cnt;
            o.cyc = cyc;
            obs_q.push_back(o);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Drive one valid vector for one edge and record its expected result.
    task automatic drive(input logic [3:0] v);
        res_t e;
        in_valid = 1'b1;
        {a, b, r1, r2} = v;
        e.y   = (v[3] & v[2]) ^ v[1] ^ v[0];
        e.hd  = 3'($countones(v ^ m_prev));
        e.cnt = m_cnt + 8'd1;
        e.cyc = 0;
        exp_q.push_back(e);
        m_prev = v;
        m_cnt  = m_cnt + 8'd1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_prev = '0;
        m_cnt  = '0;
        exp_q.delete();
        obs_q.delete();
    endtask

    // Bounded wait until the monitor has seen as many beats as were expected.
    task automatic wait_drain();
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 200 && obs_q.size() < exp_q.size(); k++) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; VPWR = 1'b1; VGND = 1'b0; in_valid = 1'b0;
        {a, b, r1, r2} = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (y !== 1'b0 || out_valid !== 1'b0 || hd !== 3'd0 || vec_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset: got y=%b ov=%b hd=%0d cnt=%0d, required all 0", y, out_valid, hd, vec_cnt);
        end else $display("[TB] reset ok");
        rst = 1'b0;
        idle(2);
        tests++;
        if (out_valid !== 1'b0 || vec_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_idle: got ov=%b cnt=%0d, required 0/0", out_valid, vec_cnt);
        end
        m_prev = '0; m_cnt = '0;
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_truth_table();
        logic [3:0] vecs [5] = '{4'b1100, 4'b1110, 4'b1111, 4'b0001, 4'b0000};
        logic       ys   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        res_t e, o;
        int   prev_cyc;
        do_reset();
        foreach (vecs[i]) drive(vecs[i]);
        wait_drain();
        prev_cyc = -1;
        for (int i = 0; i < 5 && exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++;
            if (o.y !== ys[i] || o.y !== e.y || o.hd !== e.hd || o.cnt !== e.cnt) begin
                fails++;
                $display("FAIL truth[%0d]: got y/hd/cnt %b/%0d/%0d, required %b/%0d/%0d", i, o.y, o.hd, o.cnt, ys[i], e.hd, e.cnt);
            end else $display("[TB] truth[%0d] v=%b y=%b hd=%0d cnt=%0d", i, vecs[i], o.y, o.hd, o.cnt);
            if (prev_cyc >= 0) begin
                tests++;
                if (o.cyc !== prev_cyc + 1) begin
                    fails++;
                    $display("FAIL truth_b2b[%0d]: got beat cycle %0d, required %0d", i, o.cyc, prev_cyc + 1);
                end
            end
            prev_cyc = o.cyc;
        end
        tests++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            fails++;
            $display("FAIL truth_count: leftover expected %0d observed %0d, required 0/0", exp_q.size(), obs_q.size());
        end
    endtask

    task automatic test_hamming();
        logic [2:0] hds  [2] = '{3'd4, 3'd2};
        logic [7:0] cnts [2] = '{8'd1, 8'd2};
        res_t e, o;
        do_reset();
        drive(4'b1111);
        drive(4'b0101);
        wait_drain();
        for (int i = 0; i < 2 && exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++;
            if (o.hd !== hds[i] || o.cnt !== cnts[i] || o.y !== e.y) begin
                fails++;
                $display("FAIL hamming[%0d]: got hd=%0d cnt=%0d y=%b, required hd=%0d cnt=%0d y=%b", i, o.hd, o.cnt, o.y, hds[i], cnts[i], e.y);
            end else $display("[TB] hamming[%0d] hd=%0d cnt=%0d", i, o.hd, o.cnt);
        end
        tests++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            fails++;
            $display("FAIL hamming_count: leftover expected %0d observed %0d, required 0/0", exp_q.size(), obs_q.size());
        end
    endtask

    task automatic test_sweep();
        res_t e, o;
        int   wraps = 0;
        int   n = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                drive(4'(i));
                drive(4'(j));
            end
        end
        wait_drain();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            if (o.cnt == 8'd0) wraps++;
            tests++;
            if (o.y !== e.y || o.hd !== e.hd || o.cnt !== e.cnt) begin
                fails++;
                $display("FAIL sweep[%0d]: got y/hd/cnt %b/%0d/%0d, required %b/%0d/%0d", n, o.y, o.hd, o.cnt, e.y, e.hd, e.cnt);
            end else $display("[TB] sweep[%0d] y=%b hd=%0d cnt=%0d", n, o.y, o.hd, o.cnt);
            n++;
        end
        tests++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            fails++;
            $display("FAIL sweep_count: leftover expected %0d observed %0d, required 0/0", exp_q.size(), obs_q.size());
        end
        tests++;
        if (wraps != 2 || vec_cnt !== 8'd0) begin
            fails++;
            $display("FAIL sweep_wrap: got wraps=%0d final cnt=%0d, required 2 and 0", wraps, vec_cnt);
        end
    endtask

    task automatic test_rail_fault();
        res_t e, o;
        do_reset();
        drive(4'b1100);
        wait_drain();
        void'(exp_q.pop_front()); void'(obs_q.pop_front());
        VGND = 1'b1;
        in_valid = 1'b1;
        {a, b, r1, r2} = 4'b1100;
        #1;
        tests++;
        if (y !== 1'b0) begin
            fails++;
            $display("FAIL rail_y_forced: got y=%b, required 0", y);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            tests++;
            if (y !== 1'b0 || out_valid !== 1'b0 || vec_cnt !== 8'd1) begin
                fails++;
                $display("FAIL rail_hold[%0d]: got y=%b ov=%b cnt=%0d, required 0/0/1", k, y, out_valid, vec_cnt);
            end else $display("[TB] rail_hold[%0d] y=0 ov=0 cnt=1", k);
        end
        in_valid = 1'b0;
        VGND = 1'b0;
        #1;
        tests++;
        if (y !== 1'b1) begin
            fails++;
            $display("FAIL rail_restore_y: got y=%b, required 1", y);
        end
        @(posedge clk); #1;
        drive(4'b0000);
        wait_drain();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++;
            if (o.y !== e.y || o.hd !== 3'd2 || o.cnt !== 8'd2) begin
                fails++;
                $display("FAIL rail_resume: got y/hd/cnt %b/%0d/%0d, required %b/2/2", o.y, o.hd, o.cnt, e.y);
            end else $display("[TB] rail_resume y=%b hd=%0d cnt=%0d", o.y, o.hd, o.cnt);
        end
        tests++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            fails++;
            $display("FAIL rail_count: leftover expected %0d observed %0d, required 0/0", exp_q.size(), obs_q.size());
        end
    endtask

    task automatic test_mid_reset();
        res_t e, o;
        do_reset();
        drive(4'b1100);
`ifdef INPUT_DELAY_EN
        // The vector is still in the delay stage and must never emerge.
        void'(exp_q.pop_back());
`endif
        rst = 1'b1;
        in_valid = 1'b1;
        {a, b, r1, r2} = 4'b1111;
        @(posedge clk); #1;
        tests++;
        if (y !== 1'b0 || out_valid !== 1'b0 || hd !== 3'd0 || vec_cnt !== 8'd0) begin
            fails++;
            $display("FAIL mid_reset: got y=%b ov=%b hd=%0d cnt=%0d, required all 0", y, out_valid, hd, vec_cnt);
        end else $display("[TB] mid_reset outputs cleared");
        rst = 1'b0;
        m_prev = '0; m_cnt = '0;
        for (int k = 0; k < 4; k++) begin
            idle(1);
            tests++;
            if (out_valid !== 1'b0 || vec_cnt !== 8'd0) begin
                fails++;
                $display("FAIL mid_reset_quiet[%0d]: got ov=%b cnt=%0d, required 0/0", k, out_valid, vec_cnt);
            end
        end
        drive(4'b0011);
        wait_drain();
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            tests++;
            if (o.y !== e.y || o.hd !== e.hd || o.cnt !== e.cnt) begin
                fails++;
                $display("FAIL mid_reset_stream: got y/hd/cnt %b/%0d/%0d, required %b/%0d/%0d", o.y, o.hd, o.cnt, e.y, e.hd, e.cnt);
            end else $display("[TB] mid_reset_stream y=%b hd=%0d cnt=%0d", o.y, o.hd, o.cnt);
        end
        tests++;
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            fails++;
            $display("FAIL mid_reset_count: leftover expected %0d observed %0d, required 0/0", exp_q.size(), obs_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; VPWR = 1'b1; VGND = 1'b0; in_valid = 1'b0;
        a = 1'b0; b = 1'b0; r1 = 1'b0; r2 = 1'b0;
        m_prev = '0; m_cnt = '0;
        test_reset();
        test_truth_table();
        test_hamming();
        test_sweep();
        test_rail_fault();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
